// File: rtl/puzzle_pkg.sv
// Shared types and constants for the decimal repeat transmitter.
// Optional feature macro used by the top: REPEAT_NEWLINE_EN (line terminator after each burst).
package puzzle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2,
        TERM = 2'd3
    } rep_state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // True when the byte is an ASCII decimal digit.
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Saturating decimal accumulator: acc <= min(acc*10 + digit, 2**COUNT_W-1).
// Clear has priority over a digit in the same cycle. sat_pulse flags the
// cycle in which a digit pushed the value past the maximum.
import puzzle_pkg::*;

module dec_accum #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               digit_valid,
    input  logic [3:0]         digit,
    input  logic               clear,
    output logic [COUNT_W-1:0] acc,
    output logic               sat_pulse
);

    localparam int EXT_W = COUNT_W + 4;
    localparam logic [EXT_W-1:0] MAX_EXT = {{4{1'b0}}, {COUNT_W{1'b1}}};

    logic [COUNT_W-1:0] acc_r;
    logic [EXT_W-1:0]   acc_ext_s;
    logic [EXT_W-1:0]   sum_s;
    logic               over_s;
    logic [COUNT_W-1:0] acc_nxt_s;

    // Compute acc*10 + digit in the widened domain and clamp to the counter range.
    always_comb begin
        acc_ext_s = {{4{1'b0}}, acc_r};
        sum_s     = (acc_ext_s << 3) + (acc_ext_s << 1) + {{(EXT_W-4){1'b0}}, digit};
        over_s    = (sum_s > MAX_EXT);
        if (over_s) begin
            acc_nxt_s = {COUNT_W{1'b1}};
        end else begin
            acc_nxt_s = sum_s[COUNT_W-1:0];
        end
    end

    // Accumulator register: reset, clear, or take the next saturated value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {COUNT_W{1'b0}};
        end else if (clear) begin
            acc_r <= {COUNT_W{1'b0}};
        end else if (digit_valid) begin
            acc_r <= acc_nxt_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc       = acc_r;
    assign sat_pulse = digit_valid && !clear && over_s;

endmodule

// File: rtl/dec_repeat_tx.sv
// Decimal repeat transmitter: parses ASCII decimal numbers from the RX byte
// stream and sends FILL_CHAR that many times to the TX wrapper.
// Optional feature macro: REPEAT_NEWLINE_EN -- when defined, every burst
// (including an empty one) is followed by a single 8'h0A byte.
import puzzle_pkg::*;

module dec_repeat_tx #(
    parameter int         COUNT_W   = 16,
    parameter logic [7:0] FILL_CHAR = 8'h41
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       input_valid,
    input  logic [7:0] input_data,
    input  logic       output_busy,
    output logic       output_en,
    output logic [7:0] output_data,
    output logic       busy,
    output logic       rx_dropped,
    output logic       sat
);

    rep_state_t         state_r, state_nxt_s;
    logic [COUNT_W-1:0] cnt_r, cnt_nxt_s;
    logic               have_digit_r, have_digit_nxt_s;
    logic               output_en_r, en_nxt_s;
    logic [7:0]         output_data_r, data_nxt_s;
    logic               busy_r;
    logic               rx_dropped_r, drop_s;
    logic               sat_r;

    logic [COUNT_W-1:0] acc_s;
    logic               acc_dv_s, acc_clr_s, sat_pulse_s;
    logic               in_digit_s;

`ifdef REPEAT_NEWLINE_EN
    logic term_sent_r, term_sent_nxt_s;
`endif

    dec_accum #(.COUNT_W(COUNT_W)) u_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_valid (acc_dv_s),
        .digit       (input_data[3:0]),
        .clear       (acc_clr_s),
        .acc         (acc_s),
        .sat_pulse   (sat_pulse_s)
    );

    // Next-state, strobe and accumulator control for the repeat FSM.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        have_digit_nxt_s = have_digit_r;
        en_nxt_s         = 1'b0;
        data_nxt_s       = output_data_r;
        acc_dv_s         = 1'b0;
        acc_clr_s        = 1'b0;
        drop_s           = 1'b0;
        in_digit_s       = is_digit(input_data);
`ifdef REPEAT_NEWLINE_EN
        term_sent_nxt_s  = term_sent_r;
`endif
        case (state_r)
            IDLE: begin
                if (input_valid) begin
                    if (in_digit_s) begin
                        acc_dv_s         = 1'b1;
                        have_digit_nxt_s = 1'b1;
                    end else if (have_digit_r) begin
                        // Terminator: latch the number and start the burst.
                        cnt_nxt_s        = acc_s;
                        acc_clr_s        = 1'b1;
                        have_digit_nxt_s = 1'b0;
                        state_nxt_s      = EMIT;
                    end else begin
                        // Separator with no pending number is simply skipped.
                        have_digit_nxt_s = have_digit_r;
                    end
                end else begin
                    have_digit_nxt_s = have_digit_r;
                end
            end
            EMIT: begin
                drop_s = input_valid;
                if (cnt_r == {COUNT_W{1'b0}}) begin
                    state_nxt_s = TERM;
                end else if (!output_busy) begin
                    en_nxt_s    = 1'b1;
                    data_nxt_s  = FILL_CHAR;
                    cnt_nxt_s   = cnt_r - {{(COUNT_W-1){1'b0}}, 1'b1};
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            GAP: begin
                drop_s = input_valid;
                // The cycle showing our own strobe never counts as TX idle.
                if (!output_en_r && !output_busy) begin
                    state_nxt_s = EMIT;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            TERM: begin
                drop_s = input_valid;
`ifdef REPEAT_NEWLINE_EN
                if (!term_sent_r) begin
                    if (!output_busy) begin
                        en_nxt_s        = 1'b1;
                        data_nxt_s      = ASCII_LF;
                        term_sent_nxt_s = 1'b1;
                    end else begin
                        term_sent_nxt_s = 1'b0;
                    end
                end else if (!output_en_r && !output_busy) begin
                    term_sent_nxt_s = 1'b0;
                    state_nxt_s     = IDLE;
                end else begin
                    state_nxt_s = TERM;
                end
`else
                state_nxt_s = IDLE;
`endif
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, counter, registered outputs and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= {COUNT_W{1'b0}};
            have_digit_r  <= 1'b0;
            output_en_r   <= 1'b0;
            output_data_r <= 8'h00;
            busy_r        <= 1'b0;
            rx_dropped_r  <= 1'b0;
            sat_r         <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            have_digit_r  <= have_digit_nxt_s;
            output_en_r   <= en_nxt_s;
            output_data_r <= data_nxt_s;
            busy_r        <= (state_nxt_s != IDLE);
            rx_dropped_r  <= rx_dropped_r | drop_s;
            sat_r         <= sat_r | sat_pulse_s;
        end
    end

`ifdef REPEAT_NEWLINE_EN
    // Tracks whether the line terminator of the current burst has been strobed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            term_sent_r <= 1'b0;
        end else begin
            term_sent_r <= term_sent_nxt_s;
        end
    end
`endif

    assign output_en   = output_en_r;
    assign output_data = output_data_r;
    assign busy        = busy_r;
    assign rx_dropped  = rx_dropped_r;
    assign sat         = sat_r;

endmodule

// File: tb/tb_dec_repeat_tx.sv
// Directed bench for dec_repeat_tx: a 16-bit instance and a 4-bit instance
// share the RX stimulus; each has its own TX model (busy for 10 cycles after
// every strobe) and a strobe monitor.
module tb_dec_repeat_tx;

    localparam logic [7:0] FILL = 8'h41;
`ifdef REPEAT_NEWLINE_EN
    localparam int NL = 1;
`else
    localparam int NL = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       input_valid;
    logic [7:0] input_data;

    logic       obusy_a, oen_a, busy_a, drop_a, sat_a;
    logic [7:0] odata_a;
    logic       obusy_b, oen_b, busy_b, drop_b, sat_b;
    logic [7:0] odata_b;

    dec_repeat_tx #(.COUNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .input_valid(input_valid), .input_data(input_data),
        .output_busy(obusy_a), .output_en(oen_a), .output_data(odata_a),
        .busy(busy_a), .rx_dropped(drop_a), .sat(sat_a)
    );

    dec_repeat_tx #(.COUNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .input_valid(input_valid), .input_data(input_data),
        .output_busy(obusy_b), .output_en(oen_b), .output_data(odata_b),
        .busy(busy_b), .rx_dropped(drop_b), .sat(sat_b)
    );

    int checks = 0;
    int errors = 0;

    // TX models and strobe monitors
    int txc_a = 0, txc_b = 0;
    int fill_a = 0, lf_a = 0, bad_a = 0, space_a = 0, ob_a = 0;
    int fill_b = 0, lf_b = 0;
    logic prev_a = 1'b0;

    assign obusy_a = (txc_a != 0);
    assign obusy_b = (txc_b != 0);

    always @(posedge clk) begin
        if (!rst_n) txc_a <= 0;
        else if (oen_a) txc_a <= 10;
        else if (txc_a != 0) txc_a <= txc_a - 1;
        if (!rst_n) txc_b <= 0;
        else if (oen_b) txc_b <= 10;
        else if (txc_b != 0) txc_b <= txc_b - 1;
    end

    always @(posedge clk) begin
        if (oen_a) begin
            if (odata_a == FILL) fill_a <= fill_a + 1;
            else if (odata_a == 8'h0A) lf_a <= lf_a + 1;
            else bad_a <= bad_a + 1;
            if (prev_a) space_a <= space_a + 1;
            if (obusy_a) ob_a <= ob_a + 1;
        end
        prev_a <= oen_a;
        if (oen_b) begin
            if (odata_b == FILL) fill_b <= fill_b + 1;
            else if (odata_b == 8'h0A) lf_b <= lf_b + 1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; input_valid = 1'b0; input_data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        input_valid = 1'b1; input_data = b;
        @(negedge clk);
        input_valid = 1'b0; input_data = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy_a || obusy_a || busy_b || obusy_b) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: timeout after %0d cycles, required idle", n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (oen_a !== 1'b0) begin errors++; $display("FAIL reset_output_en: got %b want 0", oen_a); end
        checks++; if (odata_a !== 8'h00) begin errors++; $display("FAIL reset_output_data: got %h want 00", odata_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        checks++; if (drop_a !== 1'b0) begin errors++; $display("FAIL reset_rx_dropped: got %b want 0", drop_a); end
        checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", sat_a); end
    endtask

    task automatic test_single();
        int f0, l0, b0, s0, o0;
        do_reset();
        f0 = fill_a; l0 = lf_a; b0 = bad_a; s0 = space_a; o0 = ob_a;
        send_str("3\n");
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b want 1", busy_a); end
        wait_idle(2000);
        checks++; if (fill_a - f0 !== 3) begin errors++; $display("FAIL single_fills: got %0d want 3", fill_a - f0); end
        checks++; if (lf_a - l0 !== NL) begin errors++; $display("FAIL single_lf: got %0d want %0d", lf_a - l0, NL); end
        checks++; if (bad_a - b0 !== 0) begin errors++; $display("FAIL single_bad_bytes: got %0d want 0", bad_a - b0); end
        checks++; if (space_a - s0 !== 0) begin errors++; $display("FAIL single_spacing: got %0d adjacent strobes want 0", space_a - s0); end
        checks++; if (ob_a - o0 !== 0) begin errors++; $display("FAIL single_en_while_busy: got %0d want 0", ob_a - o0); end
    endtask

    task automatic test_multi_digit();
        int f0, s0, o0;
        do_reset();
        f0 = fill_a; s0 = space_a; o0 = ob_a;
        send_str("123 ");
        wait_idle(5000);
        checks++; if (fill_a - f0 !== 123) begin errors++; $display("FAIL multi_fills: got %0d want 123", fill_a - f0); end
        checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL multi_sat: got %b want 0", sat_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL multi_busy_end: got %b want 0", busy_a); end
        checks++; if ((space_a - s0) + (ob_a - o0) !== 0) begin errors++; $display("FAIL multi_strobe_rules: got %0d violations want 0", (space_a - s0) + (ob_a - o0)); end
    endtask

    task automatic test_saturation();
        int f0, l0;
        do_reset();
        f0 = fill_b; l0 = lf_b;
        send_str("99\n");
        wait_idle(5000);
        checks++; if (fill_b - f0 !== 15) begin errors++; $display("FAIL sat_fills: got %0d want 15", fill_b - f0); end
        checks++; if (sat_b !== 1'b1) begin errors++; $display("FAIL sat_flag_w4: got %b want 1", sat_b); end
        checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL sat_flag_w16: got %b want 0", sat_a); end
        f0 = fill_b; l0 = lf_b;
        send_str("0\n");
        wait_idle(2000);
        checks++; if (fill_b - f0 !== 0) begin errors++; $display("FAIL zero_fills: got %0d want 0", fill_b - f0); end
        checks++; if (lf_b - l0 !== NL) begin errors++; $display("FAIL zero_lf: got %0d want %0d", lf_b - l0, NL); end
        checks++; if (sat_b !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b want 1", sat_b); end
    endtask

    task automatic test_drop();
        int f0;
        do_reset();
        f0 = fill_a;
        send_str("5\n");
        repeat (5) @(negedge clk);
        send_str("7\n");
        wait_idle(3000);
        checks++; if (fill_a - f0 !== 5) begin errors++; $display("FAIL drop_fills: got %0d want 5", fill_a - f0); end
        checks++; if (drop_a !== 1'b1) begin errors++; $display("FAIL drop_flag: got %b want 1", drop_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL drop_busy_end: got %b want 0", busy_a); end
        f0 = fill_a;
        send_str("1\n");
        wait_idle(2000);
        checks++; if (fill_a - f0 !== 1) begin errors++; $display("FAIL drop_then_idle: got %0d want 1", fill_a - f0); end
    endtask

    task automatic test_separators();
        int f0;
        do_reset();
        f0 = fill_a;
        send_str("\n\n 2,");
        wait_idle(2000);
        checks++; if (fill_a - f0 !== 2) begin errors++; $display("FAIL sep_fills: got %0d want 2", fill_a - f0); end
        checks++; if (drop_a !== 1'b0) begin errors++; $display("FAIL sep_dropped: got %b want 0", drop_a); end
    endtask

    task automatic test_reset_mid_burst();
        int f0, n;
        do_reset();
        f0 = fill_a;
        send_str("9\n");
        n = 0;
        while ((fill_a - f0) < 4 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (fill_a - f0 !== 4) begin errors++; $display("FAIL midrst_reach4: got %0d want 4", fill_a - f0); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (oen_a !== 1'b0) begin errors++; $display("FAIL midrst_output_en: got %b want 0", oen_a); end
        checks++; if (odata_a !== 8'h00) begin errors++; $display("FAIL midrst_output_data: got %h want 00", odata_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy_a); end
        repeat (200) @(negedge clk);
        checks++; if (fill_a - f0 !== 4) begin errors++; $display("FAIL midrst_no_more: got %0d want 4", fill_a - f0); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle: got %b want 0", busy_a); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_digit();
        test_saturation();
        test_drop();
        test_separators();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
